br_resolve_ctrl: RTL and testbench
==================================

Name: br_resolve_ctrl

Overview:
- Branch-resolution controller for the pipelined LC-3b datapath.
- Owns the architectural condition-code register and tracks CC-writing instructions in flight.
- Holds a BR request until its condition codes are final, then compares CC against the instruction's nzp field and issues a one-cycle ack with taken/redirect/flush.
- Sits between decode (CC issue, BR request), writeback (CC write) and fetch (redirect).

Parameters:
- MAX_INFLIGHT, 3: maximum CC-writing instructions in flight; the pending counter saturates here.
- CNT_W, 2: pending-counter width; must satisfy 2**CNT_W > MAX_INFLIGHT.
- CC_RESET, 3'b010: CC register value after reset (Z).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cc_issue  in  1  a CC-writing instruction entered the pipeline this cycle
- cc_wb  in  1  a CC-writing instruction writes back this cycle
- cc_wdata  in  16  writeback data used to derive nzp
- br_req  in  1  BR request valid; held until br_ack
- br_nzp  in  3  BR nzp field {n,z,p}; stable while br_req=1
- br_target  in  16  precomputed branch target; stable while br_req=1
- br_ack  out  1  one-cycle resolution pulse
- br_taken  out  1  resolution result; valid with br_ack
- pc_redirect  out  16  br_target latched at resolution; valid with br_ack
- flush  out  1  equals br_ack & br_taken
- stall  out  1  BR present but not resolvable this cycle
- cc  out  3  architectural CC register
- cnt_err  out  1  sticky bookkeeping error

Behaviour:
- Reset:
  - cc=CC_RESET; pending=0; state=IDLE.
  - br_ack, br_taken, flush, cnt_err = 0; pc_redirect=16'h0000.
  - Reset mid-wait drops the request with no ack.
- nzp derivation from cc_wdata:
  - bit15=1 -> 3'b100
  - ==0 -> 3'b010
  - else -> 3'b001
- CC register: on cc_wb, cc <= derived nzp at the next edge. Otherwise it holds.
- Pending counter, updated each edge:
  - issue only: +1. If already at MAX_INFLIGHT, the counter holds and cnt_err is set.
  - wb only: -1. If already at 0, the counter holds and cnt_err is set.
  - issue and wb together: unchanged.
  - cnt_err clears only on reset.
- Effective CC:
  - If cc_wb=1: effective CC = derived nzp (same-cycle forward).
  - Otherwise: effective CC = the cc register.
- Resolvable (combinational), true when br_req=1 and any of:
  - br_nzp==3'b000 (never taken) or br_nzp==3'b111 (always taken); these never wait.
  - pending==0 and cc_issue=0.
  - pending==1 and cc_wb=1 and cc_issue=0.
  - A cc_issue in the same cycle as the BR belongs to an older instruction and blocks resolution.
- Decision: taken = |(br_nzp & effective CC).
- FSM (IDLE, WAIT, ACK):
  - IDLE: br_req & resolvable -> ACK and latch taken/br_target. br_req & !resolvable -> WAIT. Otherwise stay.
  - WAIT: resolvable -> ACK and latch. Otherwise stay. br_req dropping in WAIT is illegal; the block returns to IDLE with no ack.
  - ACK: br_ack=1, br_taken and pc_redirect driven, flush=br_taken. br_req is ignored this cycle. -> IDLE unconditionally.
- Latency: a resolvable request gives br_ack one cycle after first presentation. Back-to-back BRs have at least a 1-cycle bubble.
- stall = br_req & !resolvable & (state != ACK), combinational.
- br_ack is never asserted for two consecutive cycles.
- CC and pending updates continue in every state.

Decomposition:
- lc3b_types additions:
  - lc3b_nzp (3-bit) and lc3b_word (16-bit), both reused.
  - new enum lc3b_br_state {IDLE, WAIT, ACK}.
  - constant CC_RESET_VAL.
- One sub-module, cc_gen: 16-bit word -> lc3b_nzp, combinational. It is reused by the datapath CC logic.
- The existing nzp comparison is instantiated for the taken decision.

Test Plan:
- Reset then br_req, br_nzp=3'b010, pending=0 -> br_ack next cycle, br_taken=1, flush=1, pc_redirect=br_target (e.g. 16'h3000).
- cc_issue at t0; at t1 br_req with br_nzp=3'b100; at t3 cc_wb with cc_wdata=16'h8001 -> stall=1 at t1–t2; forwarded resolution at t3; br_ack at t4 with taken=1; cc=3'b100 at t4.
- Same sequence with cc_wdata=16'h0005 and br_nzp=3'b110 -> br_ack with br_taken=0, flush=0; cc=3'b001.
- br_nzp=3'b111 with pending=2 -> br_ack next cycle, taken=1, stall never asserted. br_nzp=3'b000 -> br_ack, taken=0.
- Counter edge cases:
  - 4 consecutive cc_issue -> pending saturates at 3, cnt_err=1.
  - After reset, cc_wb alone -> cnt_err=1, pending stays 0.
  - Simultaneous issue+wb at pending=1 -> pending stays 1.
- Reset asserted in WAIT -> next cycle state IDLE, br_ack=0, pending=0, cc=3'b010.

Source files
------------

// File: rtl/br_resolve_ctrl_pkg.sv
// Shared LC-3b types for the branch-resolution slice: nzp/word types, BR FSM states, CC reset value.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package br_resolve_ctrl_pkg;

  typedef logic [2:0]  lc3b_nzp;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } lc3b_br_state;

  localparam lc3b_nzp CC_RESET_VAL = 3'b010;

  // A branch is taken when any condition bit it asks for is set in CC.
  function automatic logic nzp_match(input lc3b_nzp br_nzp, input lc3b_nzp cc);
    return |(br_nzp & cc);
  endfunction

endpackage

// File: rtl/br_resolve_ctrl_cc_gen.sv
// Derives the LC-3b nzp condition code from a 16-bit result word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input word.
module cc_gen
  import br_resolve_ctrl_pkg::*;
(
  input  logic [15:0] word,
  output logic [2:0]  nzp
);

  // Sign bit wins, then zero test, otherwise positive.
  always_comb begin
    nzp = 3'b001;
    if (word[15]) begin
      nzp = 3'b100;
    end else if (word == 16'h0000) begin
      nzp = 3'b010;
    end
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Owns the architectural CC register, counts CC writers in flight, and resolves BR requests once CC is final.
// Latency: a resolvable BR is acked one cycle after first presentation; back-to-back BRs see a 1-cycle bubble.
// Backpressure: stall is raised while a BR waits for older CC writers; br_req must be held until br_ack.
module br_resolve_ctrl
  import br_resolve_ctrl_pkg::*;
#(
  parameter int          MAX_INFLIGHT = 3,
  parameter int          CNT_W        = 2,
  parameter logic [2:0]  CC_RESET     = CC_RESET_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cc_issue,
  input  logic        cc_wb,
  input  logic [15:0] cc_wdata,
  input  logic        br_req,
  input  logic [2:0]  br_nzp,
  input  logic [15:0] br_target,
  output logic        br_ack,
  output logic        br_taken,
  output logic [15:0] pc_redirect,
  output logic        flush,
  output logic        stall,
  output logic [2:0]  cc,
  output logic        cnt_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  lc3b_br_state     state, state_nxt;
  logic [CNT_W-1:0] pending;
  lc3b_nzp          wb_nzp;
  lc3b_nzp          eff_cc;
  logic             resolvable;
  logic             take_now;
  logic             latch_en;
  logic             taken_q;
  lc3b_word         target_q;

  cc_gen u_cc_gen (
    .word (cc_wdata),
    .nzp  (wb_nzp)
  );

  // Forward writeback CC in the same cycle so a BR behind the last writer resolves without a bubble.
  always_comb begin
    eff_cc = cc;
    if (cc_wb) begin
      eff_cc = wb_nzp;
    end
  end

  // CC is final when no older writer remains, counting the one writing back now; nzp 000/111 never depend on CC.
  always_comb begin
    resolvable = 1'b0;
    if (br_req) begin
      if ((br_nzp == 3'b000) || (br_nzp == 3'b111)) begin
        resolvable = 1'b1;
      end else if ((pending == '0) && !cc_issue) begin
        resolvable = 1'b1;
      end else if ((pending == ONE_CNT) && cc_wb && !cc_issue) begin
        resolvable = 1'b1;
      end
    end
    take_now = nzp_match(br_nzp, eff_cc);
  end

  // Next-state logic; latch_en marks the cycle the decision and target are captured.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (br_req && resolvable) begin
          state_nxt = ACK;
          latch_en  = 1'b1;
        end else if (br_req) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!br_req) begin
          state_nxt = IDLE;
        end else if (resolvable) begin
          state_nxt = ACK;
          latch_en  = 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus latched resolution result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      taken_q  <= 1'b0;
      target_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        taken_q  <= take_now;
        target_q <= br_target;
      end
    end
  end

  // Architectural CC and in-flight bookkeeping run in every FSM state; over/underflow holds and flags sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cc      <= CC_RESET;
      pending <= '0;
      cnt_err <= 1'b0;
    end else begin
      if (cc_wb) begin
        cc <= wb_nzp;
      end
      if (cc_issue && !cc_wb) begin
        if (pending == MAX_CNT) begin
          cnt_err <= 1'b1;
        end else begin
          pending <= pending + ONE_CNT;
        end
      end else if (cc_wb && !cc_issue) begin
        if (pending == '0) begin
          cnt_err <= 1'b1;
        end else begin
          pending <= pending - ONE_CNT;
        end
      end
    end
  end

  // Outputs are qualified by the ACK state so taken/flush only ever pulse alongside br_ack.
  always_comb begin
    br_ack      = (state == ACK);
    br_taken    = br_ack & taken_q;
    flush       = br_ack & taken_q;
    pc_redirect = target_q;
    stall       = br_req & ~resolvable & (state != ACK);
  end

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: reset, forwarding, never/always branches, counter edges, reset mid-wait.
// Latency: outputs sampled 2 time units after each rising edge, combinational outputs 1 unit after input change.
// Backpressure: br_req held from presentation until the ack cycle, then dropped.
module tb_br_resolve_ctrl;
  import br_resolve_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cc_issue;
  logic        cc_wb;
  logic [15:0] cc_wdata;
  logic        br_req;
  logic [2:0]  br_nzp;
  logic [15:0] br_target;
  logic        br_ack;
  logic        br_taken;
  logic [15:0] pc_redirect;
  logic        flush;
  logic        stall;
  logic [2:0]  cc;
  logic        cnt_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  br_resolve_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cc_issue    (cc_issue),
    .cc_wb       (cc_wb),
    .cc_wdata    (cc_wdata),
    .br_req      (br_req),
    .br_nzp      (br_nzp),
    .br_target   (br_target),
    .br_ack      (br_ack),
    .br_taken    (br_taken),
    .pc_redirect (pc_redirect),
    .flush       (flush),
    .stall       (stall),
    .cc          (cc),
    .cnt_err     (cnt_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cc_issue = 1'b0; cc_wb = 1'b0; cc_wdata = 16'h0000;
    br_req = 1'b0; br_nzp = 3'b000; br_target = 16'h0000;
    do_reset();

    // Reset state
    chk("rst_cc", 32'(cc), 32'h2);
    chk("rst_ack", 32'(br_ack), 32'h0);
    chk("rst_taken", 32'(br_taken), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_err", 32'(cnt_err), 32'h0);
    chk("rst_pc", 32'(pc_redirect), 32'h0);
    chk("rst_pend", 32'(dut.pending), 32'h0);

    // Simple resolvable BR on Z with nothing in flight
    br_req = 1'b1; br_nzp = 3'b010; br_target = 16'h3000;
    #1 chk("t1_stall", 32'(stall), 32'h0);
    tick();
    chk("t1_ack", 32'(br_ack), 32'h1);
    chk("t1_taken", 32'(br_taken), 32'h1);
    chk("t1_flush", 32'(flush), 32'h1);
    chk("t1_pc", 32'(pc_redirect), 32'h3000);
    br_req = 1'b0;
    tick();
    chk("t1_ack_off", 32'(br_ack), 32'h0);

    // Wait for an older writer, forwarded negative result, taken
    cc_issue = 1'b1;
    tick();
    cc_issue = 1'b0; br_req = 1'b1; br_nzp = 3'b100; br_target = 16'h1234;
    #1 chk("t2_stall1", 32'(stall), 32'h1);
    tick();
    #1 chk("t2_stall2", 32'(stall), 32'h1);
    chk("t2_noack", 32'(br_ack), 32'h0);
    tick();
    cc_wb = 1'b1; cc_wdata = 16'h8001;
    #1 chk("t2_stall3", 32'(stall), 32'h0);
    tick();
    cc_wb = 1'b0;
    chk("t2_ack", 32'(br_ack), 32'h1);
    chk("t2_taken", 32'(br_taken), 32'h1);
    chk("t2_cc", 32'(cc), 32'h4);
    chk("t2_pc", 32'(pc_redirect), 32'h1234);
    chk("t2_pend", 32'(dut.pending), 32'h0);
    br_req = 1'b0;
    tick();

    // Same shape, positive result against nz: not taken
    cc_issue = 1'b1;
    tick();
    cc_issue = 1'b0; br_req = 1'b1; br_nzp = 3'b110; br_target = 16'h4444;
    #1 chk("t3_stall1", 32'(stall), 32'h1);
    tick();
    tick();
    cc_wb = 1'b1; cc_wdata = 16'h0005;
    #1 chk("t3_stall3", 32'(stall), 32'h0);
    tick();
    cc_wb = 1'b0;
    chk("t3_ack", 32'(br_ack), 32'h1);
    chk("t3_taken", 32'(br_taken), 32'h0);
    chk("t3_flush", 32'(flush), 32'h0);
    chk("t3_cc", 32'(cc), 32'h1);
    br_req = 1'b0;
    tick();

    // Always/never branches ignore two writers in flight
    cc_issue = 1'b1;
    tick();
    tick();
    cc_issue = 1'b0;
    chk("t4_pend2", 32'(dut.pending), 32'h2);
    br_req = 1'b1; br_nzp = 3'b111; br_target = 16'h5000;
    #1 chk("t4_stall_a", 32'(stall), 32'h0);
    tick();
    chk("t4_ack_a", 32'(br_ack), 32'h1);
    chk("t4_taken_a", 32'(br_taken), 32'h1);
    chk("t4_pc_a", 32'(pc_redirect), 32'h5000);
    br_req = 1'b0;
    tick();
    br_req = 1'b1; br_nzp = 3'b000; br_target = 16'h6000;
    #1 chk("t4_stall_n", 32'(stall), 32'h0);
    tick();
    chk("t4_ack_n", 32'(br_ack), 32'h1);
    chk("t4_taken_n", 32'(br_taken), 32'h0);
    br_req = 1'b0;
    cc_wb = 1'b1; cc_wdata = 16'h0000;
    tick();
    tick();
    cc_wb = 1'b0;
    chk("t4_pend0", 32'(dut.pending), 32'h0);
    chk("t4_err", 32'(cnt_err), 32'h0);
    chk("t4_cc", 32'(cc), 32'h2);

    // Counter saturation at three
    cc_issue = 1'b1;
    tick();
    tick();
    tick();
    chk("sat_pend3", 32'(dut.pending), 32'h3);
    chk("sat_err0", 32'(cnt_err), 32'h0);
    tick();
    cc_issue = 1'b0;
    chk("sat_pend", 32'(dut.pending), 32'h3);
    chk("sat_err1", 32'(cnt_err), 32'h1);

    // Underflow from reset
    do_reset();
    cc_wb = 1'b1; cc_wdata = 16'h0001;
    tick();
    cc_wb = 1'b0;
    chk("uf_pend", 32'(dut.pending), 32'h0);
    chk("uf_err", 32'(cnt_err), 32'h1);

    // Simultaneous issue and writeback at one in flight
    do_reset();
    cc_issue = 1'b1;
    tick();
    cc_wb = 1'b1; cc_wdata = 16'h0001;
    tick();
    cc_issue = 1'b0; cc_wb = 1'b0;
    chk("sim_pend", 32'(dut.pending), 32'h1);
    chk("sim_err", 32'(cnt_err), 32'h0);

    // Reset while waiting drops the request
    br_req = 1'b1; br_nzp = 3'b010; br_target = 16'h7000;
    tick();
    chk("rw_state_wait", 32'(dut.state), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0; br_req = 1'b0;
    chk("rw_state", 32'(dut.state), 32'(IDLE));
    chk("rw_ack", 32'(br_ack), 32'h0);
    chk("rw_pend", 32'(dut.pending), 32'h0);
    chk("rw_cc", 32'(cc), 32'h2);
    tick();
    chk("rw_ack2", 32'(br_ack), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
